// File: rtl/updown_count_monitor.sv
// Step checker for a ripple up/down counter: samples q/m on clk rising edge,
// flags any step that is not +/-1 in the commanded direction, counts wraps and errors.
module updown_count_monitor #(
    parameter int WIDTH      = 3,
    parameter int CNT_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clr_err,
    output logic             step_err,
    output logic             err_sticky,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0] expect_q,
    output logic             armed
);

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] Q_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q_q, prev_q_d;
    logic             prev_m_q, prev_m_d;
    logic             step_err_q, step_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH-1:0] exp_next_q, exp_next_d;
    logic             armed_q, armed_d;

    logic [WIDTH-1:0] step_exp;
    logic             hold_ok;
    logic             crossing;

    assign step_exp = prev_m_q ? (prev_q_q - Q_ONE) : (prev_q_q + Q_ONE);
    assign hold_ok  = (ALLOW_HOLD != 0) && (q_in == prev_q_q);
    // Only meaningful for a legal step: the step left the boundary value.
    assign crossing = prev_m_q ? (prev_q_q == '0) : (prev_q_q == Q_MAX);

    always_comb begin
        state_d      = state_q;
        prev_q_d     = q_in;
        prev_m_d     = m;
        step_err_d   = 1'b0;
        wrap_d       = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;
        exp_next_d   = m ? (q_in - Q_ONE) : (q_in + Q_ONE);

        case (state_q)
            ARM: state_d = TRACK;
            TRACK: begin
                if (m != prev_m_q) begin
                    state_d = RESYNC;
                end else if (q_in == step_exp) begin
                    if (crossing) begin
                        wrap_d = 1'b1;
                        if (wrap_cnt_q != CNT_MAX) wrap_cnt_d = wrap_cnt_q + CNT_ONE;
                    end
                end else if (!hold_ok) begin
                    step_err_d = 1'b1;
                end
            end
            RESYNC:  state_d = (m != prev_m_q) ? RESYNC : TRACK;
            default: state_d = ARM;
        endcase

        // Clear wins over a coincident error; the pulse itself is still reported.
        if (clr_err) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (step_err_d) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
        end

        armed_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARM;
            prev_q_q     <= '0;
            prev_m_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_q       <= 1'b0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
            exp_next_q   <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q_q     <= prev_q_d;
            prev_m_q     <= prev_m_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
            exp_next_q   <= exp_next_d;
            armed_q      <= armed_d;
        end
    end

    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign wrap       = wrap_q;
    assign err_cnt    = err_cnt_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign expect_q   = exp_next_q;
    assign armed      = armed_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Scoreboard bench for updown_count_monitor: a sample-history reference model
// predicts every registered output; a monitor pops and compares each cycle.
module tb_updown_count_monitor;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;
    localparam int QMOD  = 8;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m = 1'b0;
    logic [WIDTH-1:0] q_in = '0;
    logic             clr_err = 1'b0;
    logic             step_err, err_sticky, wrap, armed;
    logic [CNT_W-1:0] err_cnt, wrap_cnt;
    logic [WIDTH-1:0] expect_q;

    updown_count_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ALLOW_HOLD(0)) dut (
        .clk(clk), .rst(rst), .m(m), .q_in(q_in), .clr_err(clr_err),
        .step_err(step_err), .err_sticky(err_sticky), .wrap(wrap),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .expect_q(expect_q), .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step_err;
        int err_sticky;
        int wrap;
        int err_cnt;
        int wrap_cnt;
        int expect_q;
        int armed;
    } exp_t;

    exp_t sb[$];
    int   hq[$];
    int   hm[$];
    int   mdl_err_cnt  = 0;
    int   mdl_wrap_cnt = 0;
    int   mdl_sticky   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        hq.delete();
        hm.delete();
        mdl_err_cnt  = 0;
        mdl_wrap_cnt = 0;
        mdl_sticky   = 0;
    endfunction

    // A sample is checked when it is not the first since reset, its mode matches
    // the previous sample's, and the previous sample left the checker armed.
    function automatic void model_sample(input int qv, input int mv, input int clr);
        exp_t e;
        int   k, dir, need;
        bit   prev_armed, checked, legal, err, wr;
        hq.push_back(qv);
        hm.push_back(mv);
        k   = hq.size() - 1;
        dir = (mv != 0) ? -1 : 1;
        checked = 1'b0;
        if (k >= 1) begin
            if (k == 1) prev_armed = 1'b1;
            else        prev_armed = (hm[k-1] == hm[k-2]);
            checked = prev_armed && (hm[k] == hm[k-1]);
        end
        err = 1'b0;
        wr  = 1'b0;
        if (checked) begin
            need  = (hq[k-1] + dir + QMOD) % QMOD;
            legal = (qv == need);
            wr    = legal && (hq[k-1] == ((mv != 0) ? 0 : QMOD - 1));
            err   = !legal;
        end
        if (clr != 0) begin
            mdl_err_cnt = 0;
            mdl_sticky  = 0;
        end else if (err) begin
            mdl_sticky  = 1;
            mdl_err_cnt = (mdl_err_cnt < CMAX) ? mdl_err_cnt + 1 : CMAX;
        end
        if (wr) mdl_wrap_cnt = (mdl_wrap_cnt < CMAX) ? mdl_wrap_cnt + 1 : CMAX;
        e.step_err   = err ? 1 : 0;
        e.wrap       = wr ? 1 : 0;
        e.err_sticky = mdl_sticky;
        e.err_cnt    = mdl_err_cnt;
        e.wrap_cnt   = mdl_wrap_cnt;
        e.expect_q   = (qv + dir + QMOD) % QMOD;
        e.armed      = ((k == 0) || (hm[k] == hm[k-1])) ? 1 : 0;
        sb.push_back(e);
    endfunction

    // Inputs change before the next rising edge, like the negedge-clocked counter.
    task automatic drive(input int qv, input int mv, input int clr);
        q_in    = WIDTH'(qv);
        m       = (mv != 0);
        clr_err = (clr != 0);
        model_sample(qv, mv, clr);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step_err"}, int'(step_err), 0);
        chk({tag, "_err_sticky"}, int'(err_sticky), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
        chk({tag, "_expect_q"}, int'(expect_q), 0);
        chk({tag, "_armed"}, int'(armed), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q_in = '0;
        m = 1'b0;
        clr_err = 1'b0;
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("step_err", int'(step_err), e.step_err);
                chk("err_sticky", int'(err_sticky), e.err_sticky);
                chk("wrap", int'(wrap), e.wrap);
                chk("err_cnt", int'(err_cnt), e.err_cnt);
                chk("wrap_cnt", int'(wrap_cnt), e.wrap_cnt);
                chk("expect_q", int'(expect_q), e.expect_q);
                chk("armed", int'(armed), e.armed);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int v, cnt, mode;
        do_reset();

        // Up count with two wraps.
        for (int k = 0; k < 20; k++) drive(k % QMOD, 0, 0);
        chk("t1_wrap_cnt", int'(wrap_cnt), 2);
        chk("t1_err_sticky", int'(err_sticky), 0);

        // Down count, wrap on the first step 0->7.
        do_reset();
        drive(0, 1, 0);
        for (int k = 7; k >= 0; k--) drive(k, 1, 0);
        chk("t2_wrap_cnt", int'(wrap_cnt), 1);
        chk("t2_err_cnt", int'(err_cnt), 0);

        // Single skipped value.
        do_reset();
        drive(2, 0, 0);
        drive(3, 0, 0);
        drive(5, 0, 0);
        chk("t3_err_cnt", int'(err_cnt), 1);
        chk("t3_err_sticky", int'(err_sticky), 1);
        chk("t3_expect_q", int'(expect_q), 6);

        // Direction change at 4.
        do_reset();
        for (int k = 0; k < 4; k++) drive(k, 0, 0);
        drive(4, 1, 0);
        chk("t4_armed_after_toggle", int'(armed), 0);
        drive(3, 1, 0);
        chk("t4_armed_resumed", int'(armed), 1);
        drive(2, 1, 0);
        drive(1, 1, 0);
        chk("t4_err_cnt", int'(err_cnt), 0);

        // Saturation of err_cnt and clear priority.
        do_reset();
        v = 0;
        drive(v, 0, 0);
        for (int k = 0; k < 300; k++) begin
            v = (v + 3) % QMOD;
            drive(v, 0, 0);
        end
        chk("t5_err_cnt_sat", int'(err_cnt), 255);
        v = (v + 1) % QMOD;
        drive(v, 0, 1);
        chk("t5_clr_err_cnt", int'(err_cnt), 0);
        chk("t5_clr_sticky", int'(err_sticky), 0);
        v = (v + 3) % QMOD;
        drive(v, 0, 1);
        chk("t5_same_cycle_pulse", int'(step_err), 1);
        chk("t5_same_cycle_cnt", int'(err_cnt), 0);
        chk("t5_same_cycle_sticky", int'(err_sticky), 0);
        v = (v + 3) % QMOD;
        drive(v, 0, 0);
        chk("t5_after_clr_cnt", int'(err_cnt), 1);

        // Short asynchronous reset mid-count.
        do_reset();
        for (int k = 0; k < 14; k++) drive(k % QMOD, 0, 0);
        #1 rst = 1'b1;
        #1 chk_all_zero("t6_async");
        #1 rst = 1'b0;
        model_reset();
        drive(6, 0, 0);
        drive(7, 0, 0);
        drive(0, 0, 0);
        chk("t6_step_err", int'(step_err), 0);
        chk("t6_wrap_cnt", int'(wrap_cnt), 1);

        // Random counter with mode flips, glitches, clears and resets.
        do_reset();
        cnt  = $urandom_range(0, QMOD - 1);
        mode = $urandom_range(0, 1);
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 15) == 0) mode = 1 - mode;
            cnt = (cnt + ((mode != 0) ? -1 : 1) + QMOD) % QMOD;
            if ($urandom_range(0, 11) == 0) cnt = $urandom_range(0, QMOD - 1);
            drive(cnt, mode, ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
